// File: rtl/bounce_generator.sv
// Switch-bounce emulator: turns a clean level change into a burst of
// pseudo-random toggles on sw_out, then settles to the new level and
// holds it for a quiet period before another burst may begin.
module bounce_generator #(
   parameter int          CLK_FREQ    = 100_000_000,
   parameter real         BOUNCE_TIME = 0.005,
   parameter int          MIN_GAP     = 64,
   parameter int          GAP_BITS    = 12,
   parameter int          HOLD_CYC    = 1000,
   parameter logic [15:0] SEED        = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       level_in,
   output logic       sw_out,
   output logic       busy,
   output logic [7:0] toggles
);

   // Last cycle index of the bounce window, counted from the burst start edge.
   localparam int W_MAX  = $rtoi(CLK_FREQ * BOUNCE_TIME) - 1;
   localparam int WIN_W  = (W_MAX > 0) ? $clog2(W_MAX + 1) : 1;
   localparam int GAP_W  = GAP_BITS + 1;
   localparam int HOLD_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [15:0] LFSR_MASK = 16'hB400;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BOUNCE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   state_t              state_reg, state_next;
   logic [15:0]         lfsr_reg, lfsr_next;
   logic                level_q_reg, level_q_next;
   logic                target_reg, target_next;
   logic                sw_out_reg, sw_out_next;
   logic                busy_reg, busy_next;
   logic [7:0]          toggles_reg, toggles_next;
   logic [WIN_W-1:0]    win_cnt_reg, win_cnt_next;
   logic [GAP_W-1:0]    gap_cnt_reg, gap_cnt_next;
   logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
   logic [GAP_W-1:0]    gap_load;

   // Galois LFSR, right-shifting: the bit falling out of position 0 is
   // folded back into every tap of the mask.
   for (genvar gi = 0; gi < 16; gi++) begin : g_lfsr
      if (gi == 15) begin : g_top
         assign lfsr_next[gi] = LFSR_MASK[gi] & lfsr_reg[0];
      end else begin : g_mid
         assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (LFSR_MASK[gi] & lfsr_reg[0]);
      end
   end

   // Gap counter reload value: (MIN_GAP + random low bits) - 1, so the
   // next toggle lands exactly MIN_GAP + lfsr[GAP_BITS-1:0] edges later.
   assign gap_load = GAP_W'(MIN_GAP - 1) + {1'b0, lfsr_reg[GAP_BITS-1:0]};

   // State and datapath registers; reset returns everything, including the LFSR seed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         lfsr_reg     <= SEED_EFF;
         level_q_reg  <= 1'b0;
         target_reg   <= 1'b0;
         sw_out_reg   <= 1'b0;
         busy_reg     <= 1'b0;
         toggles_reg  <= 8'd0;
         win_cnt_reg  <= '0;
         gap_cnt_reg  <= '0;
         hold_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         lfsr_reg     <= lfsr_next;
         level_q_reg  <= level_q_next;
         target_reg   <= target_next;
         sw_out_reg   <= sw_out_next;
         busy_reg     <= busy_next;
         toggles_reg  <= toggles_next;
         win_cnt_reg  <= win_cnt_next;
         gap_cnt_reg  <= gap_cnt_next;
         hold_cnt_reg <= hold_cnt_next;
      end
   end

   // Next-state: disabling aborts to IDLE; otherwise IDLE -> BOUNCE on a
   // level mismatch, BOUNCE -> HOLD when the window expires, HOLD -> IDLE.
   always_comb begin
      state_next = state_reg;
      if (!en) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE:   if (level_in != level_q_reg) state_next = ST_BOUNCE;
            ST_BOUNCE: if (win_cnt_reg == '0)       state_next = ST_HOLD;
            ST_HOLD:   if (hold_cnt_reg == '0)      state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
         endcase
      end
   end

   // Output and counter updates for each state; settling takes priority
   // over a toggle that falls due on the same edge.
   always_comb begin
      level_q_next  = level_q_reg;
      target_next   = target_reg;
      sw_out_next   = sw_out_reg;
      busy_next     = busy_reg;
      toggles_next  = toggles_reg;
      win_cnt_next  = win_cnt_reg;
      gap_cnt_next  = gap_cnt_reg;
      hold_cnt_next = hold_cnt_reg;
      if (!en) begin
         level_q_next = level_in;
         sw_out_next  = level_in;
         busy_next    = 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               sw_out_next = level_q_reg;
               if (level_in != level_q_reg) begin
                  target_next  = level_in;
                  sw_out_next  = ~sw_out_reg;
                  toggles_next = 8'd1;
                  win_cnt_next = WIN_W'(W_MAX);
                  gap_cnt_next = gap_load;
                  busy_next    = 1'b1;
               end
            end
            ST_BOUNCE: begin
               if (win_cnt_reg == '0) begin
                  sw_out_next   = target_reg;
                  level_q_next  = target_reg;
                  hold_cnt_next = HOLD_W'(HOLD_CYC - 1);
               end else begin
                  win_cnt_next = win_cnt_reg - WIN_W'(1);
                  if (gap_cnt_reg == '0) begin
                     sw_out_next  = ~sw_out_reg;
                     gap_cnt_next = gap_load;
                     if (toggles_reg != 8'hFF) toggles_next = toggles_reg + 8'd1;
                  end else begin
                     gap_cnt_next = gap_cnt_reg - GAP_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               sw_out_next = target_reg;
               if (hold_cnt_reg == '0) begin
                  busy_next = 1'b0;
               end else begin
                  hold_cnt_next = hold_cnt_reg - HOLD_W'(1);
               end
            end
            default: begin
               busy_next = 1'b0;
            end
         endcase
      end
   end

   assign sw_out  = sw_out_reg;
   assign busy    = busy_reg;
   assign toggles = toggles_reg;

endmodule

// File: tb/tb_bounce_generator.sv
// Bench for bounce_generator: a timestamp-based reference model checks
// every cycle, plus a vector table and hand-written burst scenarios.
module tb_bounce_generator;

   localparam int          W_MAX    = 99;
   localparam int          MIN_GAP  = 2;
   localparam int          GAP_BITS = 3;
   localparam int          HOLD_CYC = 10;
   localparam logic [15:0] SEED     = 16'hACE1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b1;
   logic       level_in = 1'b0;
   logic       sw_out, busy;
   logic [7:0] toggles;

   logic       en6 = 1'b0;
   logic       level6 = 1'b0;
   logic       sw6, busy6;
   logic [7:0] toggles6;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   bounce_generator #(
      .CLK_FREQ(1_000_000), .BOUNCE_TIME(0.0001), .MIN_GAP(MIN_GAP),
      .GAP_BITS(GAP_BITS), .HOLD_CYC(HOLD_CYC), .SEED(SEED)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .level_in(level_in),
      .sw_out(sw_out), .busy(busy), .toggles(toggles)
   );

   bounce_generator #(
      .CLK_FREQ(1_000_000), .BOUNCE_TIME(0.002), .MIN_GAP(1),
      .GAP_BITS(1), .HOLD_CYC(10), .SEED(SEED)
   ) dut6 (
      .clk(clk), .reset(reset), .en(en6), .level_in(level6),
      .sw_out(sw6), .busy(busy6), .toggles(toggles6)
   );

   // Reference model: bursts are described by absolute edge timestamps
   // (settle time, next toggle time, end of hold) rather than counters.
   int          m_cyc;
   bit          m_sw, m_busy, m_lq, m_target;
   int          m_tog;
   int          m_phase;   // 0 quiet, 1 bouncing, 2 holding
   int          m_settle_at, m_next_tog, m_idle_at;
   logic [15:0] m_lfsr;

   function automatic logic [15:0] lfsr_step(input logic [15:0] x);
      return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic model_reset();
      m_cyc = 0; m_sw = 0; m_busy = 0; m_lq = 0; m_target = 0;
      m_tog = 0; m_phase = 0; m_lfsr = SEED;
   endtask

   task automatic model_edge();
      int gap;
      gap = MIN_GAP + int'(m_lfsr[GAP_BITS-1:0]);
      if (!en) begin
         m_phase = 0; m_busy = 0; m_sw = level_in; m_lq = level_in;
      end else if (m_phase == 0) begin
         if (level_in != m_lq) begin
            m_target = level_in; m_sw = !m_sw; m_tog = 1; m_busy = 1;
            m_settle_at = m_cyc + W_MAX + 1;
            m_next_tog = m_cyc + gap;
            m_phase = 1;
         end else begin
            m_sw = m_lq;
         end
      end else if (m_phase == 1) begin
         if (m_cyc == m_settle_at) begin
            m_sw = m_target; m_lq = m_target;
            m_idle_at = m_cyc + HOLD_CYC;
            m_phase = 2;
         end else if (m_cyc == m_next_tog) begin
            m_sw = !m_sw;
            if (m_tog < 255) m_tog++;
            m_next_tog = m_cyc + gap;
         end
      end else begin
         m_sw = m_target;
         if (m_cyc == m_idle_at) begin
            m_phase = 0; m_busy = 0;
         end
      end
      m_lfsr = lfsr_step(m_lfsr);
      m_cyc++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, m_cyc, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int v, input int lo, input int hi);
      n_chk++;
      if (v < lo || v > hi) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d..%0d", name, m_cyc, v, lo, hi);
      end
   endtask

   // One clock edge: advance the model, then compare all outputs 1 time unit later.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("sw_out", sw_out, m_sw);
      chk("busy", busy, m_busy);
      chk("toggles", toggles, m_tog);
   endtask

   // Asynchronous reset applied between edges; outputs must clear at once.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_sw", sw_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_toggles", toggles, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   typedef struct {
      bit en;
      bit lvl;
      bit exp_sw;
      bit exp_busy;
      int exp_tog;
   } vec_t;

   vec_t vecs[43];
   bit   trace1[0:110];

   initial begin
      int n_edges, last_t;
      logic prev;
      bit l;

      // Vector table: burst start toward 0, one quiet cycle, abort, then
      // pass-through with level_in toggling every 5 cycles.
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1};
      vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1};
      for (int i = 0; i < 40; i++) begin
         l = ((i / 5) % 2) == 0;
         vecs[3+i] = '{1'b0, l, l, 1'b0, 1};
      end

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("init_sw", sw_out, 0);
      chk("init_busy", busy, 0);
      chk("init_toggles", toggles, 0);

      // Quiet input: nothing happens.
      for (int i = 0; i < 200; i++) tick();
      $display("quiet: 200 cycles, sw_out=%0d busy=%0d toggles=%0d", sw_out, busy, toggles);

      // Burst toward 1.
      level_in = 1'b1;
      tick();
      trace1[0] = m_sw;
      chk("s2_sw_at_E", sw_out, 1);
      chk("s2_busy_at_E", busy, 1);
      prev = sw_out; n_edges = 1; last_t = 0;
      for (int i = 1; i <= 110; i++) begin
         tick();
         trace1[i] = m_sw;
         if (i <= W_MAX && sw_out !== prev) begin
            n_edges++;
            chk_range("s2_gap", i - last_t, MIN_GAP, MIN_GAP + (1 << GAP_BITS) - 1);
            last_t = i;
         end
         prev = sw_out;
         if (i >= 100) chk("s2_settled", sw_out, 1);
         if (i == 100) chk("s2_toggle_count", toggles, n_edges);
         if (i == 109) chk("s2_busy_hold", busy, 1);
         if (i == 110) chk("s2_busy_end", busy, 0);
      end
      $display("burst 1: %0d toggles, settled sw_out=%0d", n_edges, sw_out);

      // Table-driven abort and pass-through.
      for (int i = 0; i < 43; i++) begin
         en = vecs[i].en;
         level_in = vecs[i].lvl;
         tick();
         chk("vec_sw", sw_out, vecs[i].exp_sw);
         chk("vec_busy", busy, vecs[i].exp_busy);
         chk("vec_toggles", toggles, vecs[i].exp_tog);
         $display("vec %0d: en=%0d level_in=%0d -> sw_out=%0d busy=%0d toggles=%0d",
                  i, vecs[i].en, vecs[i].lvl, sw_out, busy, toggles);
      end
      en = 1'b1;
      level_in = 1'b0;
      for (int i = 0; i < 3; i++) tick();

      // Input change during a burst is ignored; the mismatch restarts afterwards.
      level_in = 1'b1;
      tick();
      chk("s3_sw_at_E", sw_out, 1);
      chk("s3_busy_at_E", busy, 1);
      for (int i = 1; i <= 230; i++) begin
         if (i == 20) level_in = 1'b0;
         tick();
         if (i == 100) begin chk("s3_settle1", sw_out, 1); chk("s3_busy_hold", busy, 1); end
         if (i == 110) begin chk("s3_idle_sw", sw_out, 1); chk("s3_idle_busy", busy, 0); end
         if (i == 111) begin chk("s3_restart_sw", sw_out, 0); chk("s3_restart_busy", busy, 1); end
         if (i >= 211) chk("s3_settle0", sw_out, 0);
         if (i == 221) chk("s3_busy_end", busy, 0);
      end
      $display("restart burst: final sw_out=%0d toggles=%0d", sw_out, toggles);

      // Reset mid-burst, then a rerun must reproduce the first burst exactly.
      do_reset();
      level_in = 1'b0;
      for (int i = 0; i < 200; i++) tick();
      level_in = 1'b1;
      for (int i = 0; i <= 40; i++) begin
         tick();
         chk("s5_pre_trace", sw_out, trace1[i]);
      end
      do_reset();
      level_in = 1'b0;
      for (int i = 0; i < 200; i++) tick();
      level_in = 1'b1;
      for (int i = 0; i <= 110; i++) begin
         tick();
         chk("s5_rerun_trace", sw_out, trace1[i]);
      end
      $display("rerun after reset: sw_out=%0d toggles=%0d", sw_out, toggles);

      // Level already high at reset release: burst on the first edge.
      en = 1'b1;
      level_in = 1'b1;
      do_reset();
      tick();
      chk("rel_high_sw", sw_out, 1);
      chk("rel_high_busy", busy, 1);

      // Randomized en / level_in traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) en = ~en;
         if ($urandom_range(0, 24) == 0) level_in = ~level_in;
         tick();
      end
      $display("random: 3000 cycles, errors so far %0d", n_err);

      // Long window with short gaps: toggle counter saturates.
      en = 1'b1;
      level_in = 1'b0;
      en6 = 1'b1;
      level6 = 1'b0;
      do_reset();
      tick();
      level6 = 1'b1;
      tick();
      chk("s6_sw_at_E", sw6, 1);
      chk("s6_busy_at_E", busy6, 1);
      chk("s6_toggles_at_E", toggles6, 1);
      for (int i = 1; i <= 2010; i++) begin
         tick();
         if (i == 600)  chk("s6_sat_early", toggles6, 255);
         if (i == 1999) chk("s6_sat_end", toggles6, 255);
         if (i == 1999) chk("s6_busy_window", busy6, 1);
         if (i >= 2000) chk("s6_settled", sw6, 1);
         if (i == 2009) chk("s6_busy_hold", busy6, 1);
         if (i == 2010) chk("s6_busy_end", busy6, 0);
         if (i == 2010) chk("s6_toggles_kept", toggles6, 255);
      end
      $display("saturating burst: sw_out=%0d toggles=%0d", sw6, toggles6);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
